// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM states, reset cause
// encodings and the counter-width helper.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        RELEASE
    } state_t;

    localparam logic [1:0] CAUSE_POR = 2'd0;
    localparam logic [1:0] CAUSE_BTN = 2'd1;
    localparam logic [1:0] CAUSE_SW  = 2'd2;

    // One spare bit above $clog2 so the counter can hold max_val itself.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
// The reset value is a parameter so idle levels can be chosen per use.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// System reset controller: qualifies a held button or a software request,
// asserts all reset channels together, then releases them in staggered order.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_OUT      = 3,
    parameter int unsigned HOLD_CYCLES  = 10,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned STAGGER      = 2
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Btn_L,
    input  logic               Sw_Req,
    output logic [NUM_OUT-1:0] Rst_Out,
    output logic               Busy,
    output logic [1:0]         Cause
);

    localparam int unsigned HW  = cnt_width(HOLD_CYCLES);
    localparam int unsigned PW  = cnt_width(PULSE_CYCLES);
    localparam int unsigned SGW = cnt_width(STAGGER);
    localparam int unsigned CW  = cnt_width(NUM_OUT);

    localparam logic [HW-1:0]  HOLD_MAX   = HW'(HOLD_CYCLES);
    localparam logic [PW-1:0]  PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [SGW-1:0] STAG_LAST  = SGW'(STAGGER - 1);
    localparam logic [CW-1:0]  CH_LAST    = CW'(NUM_OUT - 1);

    logic             btn_s;
    logic [HW-1:0]    hold_cnt;
    logic             btn_trig;
    logic             trigger;
    logic [1:0]       trig_cause;

    state_t           state, state_d;
    logic [PW-1:0]    pulse_cnt, pulse_d;
    logic [SGW-1:0]   stag_cnt, stag_d;
    logic [CW-1:0]    ch_idx, ch_d;
    logic [NUM_OUT-1:0] rst_d;
    logic [1:0]       cause_d;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_btn_sync (
        .clk (CLK),
        .rst (Reset),
        .d   (Btn_L),
        .q   (btn_s)
    );

    // Runs in every state so a press held through a sequence still counts.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            hold_cnt <= '0;
        end else if (btn_s) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // hold_cnt still carries the press length on the first released cycle.
    assign btn_trig   = btn_s && (hold_cnt == HOLD_MAX);
    assign trigger    = btn_trig || Sw_Req;
    assign trig_cause = btn_trig ? CAUSE_BTN : CAUSE_SW;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= ASSERT;
            pulse_cnt <= '0;
            stag_cnt  <= '0;
            ch_idx    <= '0;
        end else begin
            state     <= state_d;
            pulse_cnt <= pulse_d;
            stag_cnt  <= stag_d;
            ch_idx    <= ch_d;
        end
    end

    always_comb begin
        state_d = state;
        pulse_d = pulse_cnt;
        stag_d  = stag_cnt;
        ch_d    = ch_idx;
        if (trigger) begin
            state_d = ASSERT;
            pulse_d = '0;
        end else begin
            case (state)
                ASSERT: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        ch_d    = '0;
                        stag_d  = '0;
                        state_d = (NUM_OUT == 1) ? IDLE : RELEASE;
                    end else begin
                        pulse_d = pulse_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (stag_cnt == STAG_LAST) begin
                        stag_d = '0;
                        ch_d   = ch_idx + 1'b1;
                        if (ch_idx + 1'b1 == CH_LAST) begin
                            state_d = IDLE;
                        end
                    end else begin
                        stag_d = stag_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ch_idx names the most recently released channel; higher bits stay set.
    always_comb begin
        rst_d = '0;
        case (state_d)
            ASSERT: rst_d = '1;
            RELEASE: begin
                for (int unsigned i = 0; i < NUM_OUT; i++) begin
                    rst_d[i] = (i > 32'(ch_d));
                end
            end
            default: rst_d = '0;
        endcase
        cause_d = trigger ? trig_cause : Cause;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            Rst_Out <= '1;
            Busy    <= 1'b1;
            Cause   <= CAUSE_POR;
        end else begin
            Rst_Out <= rst_d;
            Busy    <= |rst_d;
            Cause   <= cause_d;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer at default parameters: expected
// per-edge outputs are queued when stimulus is applied and checked at negedge.
module tb_reset_sequencer;

    localparam int unsigned NUM_OUT = 3;
    localparam int unsigned HOLD    = 10;
    localparam int unsigned PULSE   = 4;
    localparam int unsigned STAG    = 2;
    localparam int unsigned SEQ_LEN = 10;

    localparam logic [1:0] C_POR = 2'd0;
    localparam logic [1:0] C_BTN = 2'd1;
    localparam logic [1:0] C_SW  = 2'd2;

    typedef struct {
        int unsigned  cyc;
        logic [2:0]   rst;
        logic         busy;
        logic [1:0]   cause;
    } exp_t;

    logic               CLK = 1'b0;
    logic               Reset;
    logic               Btn_L;
    logic               Sw_Req;
    logic [NUM_OUT-1:0] Rst_Out;
    logic               Busy;
    logic [1:0]         Cause;

    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    exp_t        sb[$];

    reset_sequencer #(
        .NUM_OUT      (NUM_OUT),
        .HOLD_CYCLES  (HOLD),
        .PULSE_CYCLES (PULSE),
        .STAGGER      (STAG)
    ) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .Btn_L   (Btn_L),
        .Sw_Req  (Sw_Req),
        .Rst_Out (Rst_Out),
        .Busy    (Busy),
        .Cause   (Cause)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Edge a is the first edge with all channels asserted; bit k is expected
    // to drop at a + PULSE + k*STAG.
    task automatic push_seq(input int unsigned a, input logic [1:0] c, input int unsigned from_off);
        exp_t e;
        for (int unsigned o = from_off; o <= SEQ_LEN; o++) begin
            e.cyc = a + o;
            for (int unsigned k = 0; k < NUM_OUT; k++) begin
                e.rst[k] = (o < PULSE + k * STAG);
            end
            e.busy  = |e.rst;
            e.cause = c;
            sb.push_back(e);
        end
    endtask

    task automatic push_idle(input int unsigned from_c, input int unsigned to_c, input logic [1:0] c);
        exp_t e;
        for (int unsigned t = from_c; t <= to_c; t++) begin
            e.cyc   = t;
            e.rst   = '0;
            e.busy  = 1'b0;
            e.cause = c;
            sb.push_back(e);
        end
    endtask

    task automatic flush_from(input int unsigned from_c);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc >= from_c) sb.delete(i);
        end
    endtask

    always @(negedge CLK) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check_val($sformatf("rst@%0d", cyc), 32'(Rst_Out), 32'(sb[i].rst));
                check_val($sformatf("busy@%0d", cyc), 32'(Busy), 32'(sb[i].busy));
                check_val($sformatf("cause@%0d", cyc), 32'(Cause), 32'(sb[i].cause));
                sb.delete(i);
            end
        end
    end

    task automatic wait_neg(input int unsigned n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic drive_sw(output int unsigned a);
        @(negedge CLK);
        #1 Sw_Req = 1'b1;
        a = cyc + 1;
        flush_from(a);
        push_seq(a, C_SW, 0);
        @(negedge CLK);
        #1 Sw_Req = 1'b0;
    endtask

    task automatic press(input int unsigned len, input logic [1:0] prev_cause);
        int unsigned m;
        @(negedge CLK);
        #1 Btn_L = 1'b0;
        wait_neg(len);
        #1 Btn_L = 1'b1;
        m = cyc;
        if (len >= HOLD) begin
            flush_from(m + 3);
            push_seq(m + 3, C_BTN, 0);
        end else begin
            push_idle(m + 1, m + 10, prev_cause);
        end
    endtask

    task automatic check_in_reset(input string tag);
        check_val({tag, "_rst"}, 32'(Rst_Out), 32'h7);
        check_val({tag, "_busy"}, 32'(Busy), 32'h1);
        check_val({tag, "_cause"}, 32'(Cause), 32'(C_POR));
    endtask

    initial begin
        int unsigned a;
        int unsigned m;
        Reset  = 1'b0;
        Btn_L  = 1'b1;
        Sw_Req = 1'b0;
        #1 Reset = 1'b1;

        // Power-on reset held for three cycles.
        repeat (3) begin
            @(negedge CLK);
            check_in_reset("por");
        end
        #1 Reset = 1'b0;
        push_seq(cyc, C_POR, 1);
        wait_neg(14);

        press(9, C_POR);
        wait_neg(12);

        press(10, C_POR);
        wait_neg(14);

        press(25, C_BTN);
        wait_neg(14);

        drive_sw(a);
        wait_neg(14);

        // Retrigger by software once bits 0 and 1 have dropped.
        drive_sw(a);
        wait_neg(5);
        drive_sw(a);
        check_val("retrig_start", 32'(Rst_Out), 32'h7);
        wait_neg(14);

        // Qualified button release and Sw_Req in the same cycle.
        @(negedge CLK);
        #1 Btn_L = 1'b0;
        wait_neg(12);
        #1 Btn_L = 1'b1;
        m = cyc;
        wait_neg(2);
        #1 Sw_Req = 1'b1;
        flush_from(m + 3);
        push_seq(m + 3, C_BTN, 0);
        @(negedge CLK);
        #1 Sw_Req = 1'b0;
        wait_neg(14);

        // Asynchronous reset in the middle of the release phase.
        drive_sw(a);
        wait_neg(5);
        #1 Reset = 1'b1;
        flush_from(0);
        #1 check_in_reset("mid");
        @(negedge CLK);
        check_in_reset("mid_hold");
        #1 Reset = 1'b0;
        push_seq(cyc, C_POR, 1);
        wait_neg(14);

        check_val("sb_drain", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
